// File: rtl/multi_debouncer.sv
// multi_debouncer
// N-channel button/switch conditioner running on the slow sampling clock.
// Each channel passes through a two-flop synchroniser and then a stability
// filter. The filter output drives registered rise/fall edge pulses and a
// long-press detector with a level output and a one-shot pulse. The channels
// share no state.

module multi_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int HOLD_CYCLES   = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] noisy_in,
    output logic [CHANNELS-1:0] clean_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] long_press,
    output logic [CHANNELS-1:0] long_pulse
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    // The filter flips on the last of STABLE_CYCLES disagreeing samples, so
    // the counter value to match is one less than the sample count.
    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(HOLD_CYCLES);

    logic [CHANNELS-1:0] sync0_q;
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] clean_q,      clean_d;
    logic [CHANNELS-1:0] rise_q,       rise_d;
    logic [CHANNELS-1:0] fall_q,       fall_d;
    logic [CHANNELS-1:0] long_q,       long_d;
    logic [CHANNELS-1:0] long_pulse_q, long_pulse_d;
    logic [CNT_W-1:0]    cnt_q  [CHANNELS];
    logic [CNT_W-1:0]    cnt_d  [CHANNELS];
    logic [HOLD_W-1:0]   hold_q [CHANNELS];
    logic [HOLD_W-1:0]   hold_d [CHANNELS];

    // Per-channel next state: stability filter, edge pulses and the hold counter
    always_comb begin
        clean_d      = clean_q;
        rise_d       = '0;
        fall_d       = '0;
        long_d       = '0;
        long_pulse_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c]  = '0;
            hold_d[c] = '0;
        end

        for (int c = 0; c < CHANNELS; c++) begin
            // A single agreeing sample leaves the counter at zero, so any
            // bounce restarts qualification.
            if (sync1_q[c] != clean_q[c]) begin
                if (cnt_q[c] == STABLE_LAST) begin
                    clean_d[c] = sync1_q[c];
                    rise_d[c]  = sync1_q[c];
                    fall_d[c]  = ~sync1_q[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end

            // Counting starts on the edge after the rise and stops on the
            // fall edge itself. long_press therefore rises HOLD_CYCLES after
            // rise_pulse and drops together with fall_pulse.
            if (clean_q[c] && clean_d[c]) begin
                if (hold_q[c] == HOLD_MAX) begin
                    hold_d[c] = hold_q[c];
                end else begin
                    hold_d[c] = hold_q[c] + HOLD_W'(1);
                end
            end

            long_d[c]       = (hold_d[c] == HOLD_MAX);
            long_pulse_d[c] = long_d[c] & ~long_q[c];
        end
    end

    // State registers; reset takes priority over every update
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q      <= '0;
            sync1_q      <= '0;
            clean_q      <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            long_q       <= '0;
            long_pulse_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c]  <= '0;
                hold_q[c] <= '0;
            end
        end else begin
            sync0_q      <= noisy_in;
            sync1_q      <= sync0_q;
            clean_q      <= clean_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            long_q       <= long_d;
            long_pulse_q <= long_pulse_d;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c]  <= cnt_d[c];
                hold_q[c] <= hold_d[c];
            end
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign long_press = long_q;
    assign long_pulse = long_pulse_q;

endmodule
